knn_query_scheduler: RTL and testbench

Front-end controller that shares one knn_classifier core among NUM_REQ independent query requesters. It arbitrates round-robin, latches the winning query and K, sanitises K, pulses the core start, and waits for core done under a watchdog. It then returns a tagged response on a valid/ready channel. It sits directly above the classifier core and is its only driver.

---
 rtl/knn_pkg.sv | 32 +++
 rtl/knn_rr_arbiter.sv | 34 +++
 rtl/knn_query_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_knn_query_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// Shared types and helpers for the kNN query front-end and its classifier core.
package knn_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int NUM_FEATURES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RECOVER = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

    // Zero selects the default K; anything above the training-set size is clamped to it.
    function automatic logic [7:0] sanitize_k(
        input logic [7:0] k_in,
        input logic [7:0] k_default,
        input logic [7:0] k_max
    );
        logic [7:0] k_out;
        if (k_in == 8'd0) begin
            k_out = k_default;
        end else if (k_in > k_max) begin
            k_out = k_max;
        end else begin
            k_out = k_in;
        end
        return k_out;
    endfunction

endpackage

// File: rtl/knn_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above the pointer, with wrap.
module knn_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [ID_W:0]        w_off;
    logic [ID_W:0]        w_sum;

    // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
    always_comb begin
        w_dbl = {i_req, i_req} >> i_ptr;
        w_rot = w_dbl[NUM_REQ-1:0];
        w_off = {(ID_W+1){1'b0}};
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_off = w_rot[off] ? (ID_W+1)'(off) : w_off;
        end
        w_sum = {1'b0, i_ptr} + w_off;
        w_sum = (w_sum >= (ID_W+1)'(NUM_REQ)) ? (w_sum - (ID_W+1)'(NUM_REQ)) : w_sum;
    end

    assign o_any   = |i_req;
    assign o_idx   = w_sum[ID_W-1:0];
    assign o_grant = o_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << w_sum) : {NUM_REQ{1'b0}};

endmodule

// File: rtl/knn_query_scheduler.sv
// Shares one kNN classifier core among several requesters: round-robin accept,
// start pulse, watchdog-guarded wait for done, tagged response on valid/ready.
module knn_query_scheduler
    import knn_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int NUM_FEATURES   = NUM_FEATURES_DEF,
    parameter int NUM_TRAINING   = 50,
    parameter int K_DEFAULT      = 3,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ID_W           = 2
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NUM_REQ-1:0]                        req_valid,
    output logic [NUM_REQ-1:0]                        req_ready,
    input  logic [NUM_REQ*DATA_WIDTH*NUM_FEATURES-1:0] req_data,
    input  logic [NUM_REQ*8-1:0]                      req_k,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [ID_W-1:0]                           rsp_id,
    output logic                                      rsp_class,
    output logic                                      rsp_err,
    output logic                                      core_start,
    output logic                                      core_rst,
    output logic [DATA_WIDTH*NUM_FEATURES-1:0]        core_test_data,
    output logic [7:0]                                core_k_value,
    input  logic                                      core_done,
    input  logic                                      core_class,
    output logic                                      busy
);

    localparam int QW    = DATA_WIDTH * NUM_FEATURES;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            r_state;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [QW-1:0]     r_data;
    logic [7:0]        r_k;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rec;
    logic              r_done_prev;
    logic              r_core_start;
    logic              r_rsp_valid;
    logic              r_rsp_class;
    logic              r_rsp_err;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic               w_any;
    logic [QW-1:0]      w_sel_data;
    logic [7:0]         w_sel_k;
    logic               w_done_edge;
    logic               w_timeout;
    logic [ID_W-1:0]    w_ptr_next;

    knn_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // One-hot grant makes an OR of masked slices a plain multiplexer.
    always_comb begin
        w_sel_data = {QW{1'b0}};
        w_sel_k    = 8'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_data = w_sel_data | ({QW{w_grant[i]}} & req_data[i*QW +: QW]);
            w_sel_k    = w_sel_k | ({8{w_grant[i]}} & req_k[i*8 +: 8]);
        end
    end

    assign w_done_edge = core_done & ~r_done_prev;
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_ptr_next  = (r_id == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : (r_id + {{(ID_W-1){1'b0}}, 1'b1});

    assign req_ready      = (rst_n && (r_state == ST_IDLE)) ? w_grant : {NUM_REQ{1'b0}};
    assign busy           = (r_state != ST_IDLE);
    assign core_rst       = ~rst_n | (r_state == ST_RECOVER);
    assign core_start     = r_core_start;
    assign core_test_data = r_data;
    assign core_k_value   = r_k;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_id         = r_id;
    assign rsp_class      = r_rsp_class;
    assign rsp_err        = r_rsp_err;

    // Previous core_done level, so a done left high from the last query is not a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_prev <= 1'b0;
        end else begin
            r_done_prev <= core_done;
        end
    end

    // Scheduler FSM with latches, watchdog and registered response fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= {ID_W{1'b0}};
            r_id         <= {ID_W{1'b0}};
            r_data       <= {QW{1'b0}};
            r_k          <= 8'd0;
            r_cnt        <= {CNT_W{1'b0}};
            r_rec        <= 1'b0;
            r_core_start <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_class  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_id         <= w_idx;
                        r_data       <= w_sel_data;
                        r_k          <= sanitize_k(w_sel_k, 8'(K_DEFAULT), 8'(NUM_TRAINING));
                        r_core_start <= 1'b1;
                        r_rsp_class  <= 1'b0;
                        r_rsp_err    <= 1'b0;
                        r_state      <= ST_ISSUE;
                    end else begin
                        r_core_start <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    r_core_start <= 1'b0;
                    r_cnt        <= {CNT_W{1'b0}};
                    r_state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion takes priority over an expiring watchdog in the same cycle.
                    if (w_done_edge) begin
                        r_rsp_class <= core_class;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_class <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rec       <= 1'b0;
                        r_state     <= ST_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RECOVER: begin
                    if (r_rec) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_rec <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_rsp_valid <= 1'b1;
                    end
                end
                default: begin
                    r_core_start <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_knn_query_scheduler.sv
// Directed + randomized bench for knn_query_scheduler with a behavioural classifier-core model.
module tb_knn_query_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_data;
    logic [31:0] req_k;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic        rsp_class;
    logic        rsp_err;
    logic        core_start;
    logic        core_rst;
    logic [15:0] core_test_data;
    logic [7:0]  core_k_value;
    logic        core_done  = 1'b0;
    logic        core_class = 1'b0;
    logic        busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] rd [4];
    logic [7:0]  rk [4];
    int          m_ptr = 0;
    bit          hang_mode = 1'b0;
    int          lat_cfg = 4;

    always #5 clk = ~clk;

    knn_query_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_data       (req_data),
        .req_k          (req_k),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_class      (rsp_class),
        .rsp_err        (rsp_err),
        .core_start     (core_start),
        .core_rst       (core_rst),
        .core_test_data (core_test_data),
        .core_k_value   (core_k_value),
        .core_done      (core_done),
        .core_class     (core_class),
        .busy           (busy)
    );

    function automatic logic model_class(input logic [15:0] d);
        int s;
        s = int'(d[7:0]) + int'(d[15:8]);
        return (s >= 128) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic [7:0] model_k(input logic [7:0] k);
        if (k == 8'd0) return 8'd3;
        if (k > 8'd50) return 8'd50;
        return k;
    endfunction

    function automatic int model_grant(input logic [3:0] mask);
        for (int o = 0; o < 4; o++) begin
            if (mask[(m_ptr + o) % 4]) return (m_ptr + o) % 4;
        end
        return 0;
    endfunction

    // Core model: keeps a stale done (with the wrong class) for two cycles after start,
    // then drops it and raises done with the right class after lat_cfg cycles unless hung.
    int   stale_cnt = 0;
    int   lat_cnt   = 0;
    bit   pend      = 1'b0;
    logic cls_m     = 1'b0;
    always @(negedge clk) begin
        if (core_rst) begin
            core_done  <= 1'b0;
            core_class <= 1'b0;
            pend       <= 1'b0;
            stale_cnt  <= 0;
            lat_cnt    <= 0;
        end else if (core_start) begin
            pend       <= 1'b1;
            stale_cnt  <= 2;
            lat_cnt    <= lat_cfg;
            cls_m      <= model_class(core_test_data);
            core_class <= ~model_class(core_test_data);
        end else if (pend) begin
            if (stale_cnt > 0) begin
                stale_cnt <= stale_cnt - 1;
                if (stale_cnt == 1) begin
                    core_done  <= 1'b0;
                    core_class <= 1'b0;
                end
            end else if (!hang_mode) begin
                if (lat_cnt > 1) begin
                    lat_cnt <= lat_cnt - 1;
                end else begin
                    core_done  <= 1'b1;
                    core_class <= cls_m;
                    pend       <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_reqs(input logic [3:0] mask);
        req_valid = mask;
        for (int i = 0; i < 4; i++) begin
            req_data[i*16 +: 16] = rd[i];
            req_k[i*8 +: 8]      = rk[i];
        end
    endtask

    task automatic txn(input logic [3:0] mask, input bit hang, input int lat, input bit bp, input bit keep);
        int          id;
        int          t;
        int          done_t;
        int          rc;
        bit          seen_low;
        logic        exp_cls;
        logic [15:0] exp_data;
        logic [7:0]  exp_k;
        hang_mode = hang;
        lat_cfg   = lat;
        rsp_ready = bp ? 1'b0 : 1'b1;
        drive_reqs(mask);
        #1;
        id       = model_grant(mask);
        exp_data = rd[id];
        exp_k    = model_k(rk[id]);
        exp_cls  = hang ? 1'b0 : model_class(rd[id]);
        check("req_ready_grant", req_ready, 4'b0001 << id);
        tick();
        check("core_start_pulse", core_start, 1);
        check("core_test_data", core_test_data, exp_data);
        check("core_k_value", core_k_value, exp_k);
        check("busy_issue", busy, 1);
        check("req_ready_busy", req_ready, 0);
        if (keep) begin
            rd[id] = 16'($urandom);
            rk[id] = 8'($urandom);
            drive_reqs(mask);
        end else begin
            drive_reqs(4'b0000);
        end
        t = 0; done_t = -1; rc = 0; seen_low = 1'b0;
        while (!rsp_valid && t < 1500) begin
            tick();
            t++;
            if (t == 1) check("core_start_single", core_start, 0);
            if (core_rst) rc++;
            if (core_done && seen_low && done_t < 0) done_t = t;
            if (!core_done) seen_low = 1'b1;
        end
        check("rsp_valid_seen", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_class", rsp_class, exp_cls);
        check("rsp_err", rsp_err, hang);
        if (hang) begin
            check("timeout_latency", t, 1003);
            check("recover_cycles", rc, 2);
        end else begin
            check("done_to_rsp", t, done_t + 1);
            check("core_rst_quiet", rc, 0);
        end
        if (bp) begin
            drive_reqs(4'b1111);
            for (int c = 0; c < 20; c++) begin
                tick();
                check("bp_rsp_valid", rsp_valid, 1);
                check("bp_rsp_id", rsp_id, id);
                check("bp_rsp_class", rsp_class, exp_cls);
                check("bp_rsp_err", rsp_err, hang);
                check("bp_busy", busy, 1);
                check("bp_req_ready", req_ready, 0);
            end
            drive_reqs(4'b0000);
            rsp_ready = 1'b1;
        end
        tick();
        check("rsp_done_valid", rsp_valid, 0);
        check("rsp_done_busy", busy, 0);
        m_ptr = (id + 1) % 4;
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_data  = 64'd0;
        req_k     = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rd[i] = 16'($urandom);
            rk[i] = 8'($urandom);
        end
        drive_reqs(4'b1111);
        repeat (3) tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_core_start", core_start, 0);
        check("rst_core_k", core_k_value, 0);
        drive_reqs(4'b0000);
        rst_n = 1'b1;
        tick();
        check("run_core_rst", core_rst, 0);

        rd[2] = {8'd8, 8'd4};
        rk[2] = 8'd3;
        txn(4'b0100, 1'b0, 4, 1'b0, 1'b0);

        rk[1] = 8'd7;   txn(4'b0010, 1'b0, 3, 1'b0, 1'b0);
        rk[0] = 8'd0;   txn(4'b0001, 1'b0, 5, 1'b0, 1'b0);
        rk[3] = 8'd100; txn(4'b1000, 1'b0, 2, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            check("fair_ptr", m_ptr, i % 4);
            txn(4'b1111, 1'b0, $urandom_range(1, 8), 1'b0, 1'b1);
        end

        rd[2] = 16'($urandom);
        txn(4'b0100, 1'b1, 1, 1'b0, 1'b0);
        rd[1] = 16'($urandom);
        txn(4'b0010, 1'b0, 3, 1'b0, 1'b0);

        rd[0] = 16'($urandom);
        rd[3] = 16'($urandom);
        txn(4'b1001, 1'b0, 6, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 4; j++) begin
                rd[j] = 16'($urandom);
                rk[j] = 8'($urandom);
            end
            txn(4'($urandom_range(1, 15)), 1'b0, $urandom_range(1, 12), 1'b0, 1'b0);
        end

        txn(4'b0010, 1'b0, 2, 1'b0, 1'b0);
        rd[0] = 16'hA55A;
        rk[0] = 8'd9;
        hang_mode = 1'b1;
        drive_reqs(4'b0001);
        #1;
        check("rstmid_grant", req_ready, 4'b0001);
        tick();
        drive_reqs(4'b0000);
        repeat (11) tick();
        check("rstmid_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_core_rst", core_rst, 1);
        check("rstmid_rsp_valid", rsp_valid, 0);
        check("rstmid_core_data", core_test_data, 0);
        check("rstmid_core_k", core_k_value, 0);
        check("rstmid_core_start", core_start, 0);
        check("rstmid_rsp_err", rsp_err, 0);
        repeat (3) tick();
        check("rstmid_core_rst_hold", core_rst, 1);
        rst_n     = 1'b1;
        hang_mode = 1'b0;
        m_ptr     = 0;
        tick();
        check("rstmid_core_rst_rel", core_rst, 0);
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid) seen = 1;
        end
        check("rstmid_no_rsp", seen, 0);
        for (int j = 0; j < 4; j++) rd[j] = 16'($urandom);
        txn(4'b1111, 1'b0, 3, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
